// File: rtl/wbpportx_pkg.sv
// Shared constants, status-word layout and FIFO depth clamp for the wbpportx parallel port.
package wbpportx_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_FIFO  = 2'd1;
    localparam logic [1:0] ADDR_RXREG = 2'd2;
    localparam logic [1:0] ADDR_TXREG = 2'd3;

    localparam int unsigned STAT_OVFL_BIT  = 17;
    localparam int unsigned STAT_FLAG_BIT  = 16;
    localparam int unsigned CTRL_RXRST_BIT = 16;
    localparam int unsigned CTRL_TXRST_BIT = 17;

    localparam int unsigned LGFLEN_MIN = 2;
    localparam int unsigned LGFLEN_MAX = 10;

    // RXREG/TXREG read word: flag is EMPTY for RX and FULL for TX
    typedef struct packed {
        logic [13:0] rsvd;
        logic        ovfl;
        logic        flag;
        logic [15:0] data;
    } stat_word_t;

    function automatic int unsigned clamp_lgflen(input int unsigned v);
        if (v < LGFLEN_MIN) return LGFLEN_MIN;
        if (v > LGFLEN_MAX) return LGFLEN_MAX;
        return v;
    endfunction

endpackage

// File: rtl/wbpportx_if.sv
// Wishbone classic-pipelined slave bundle for wbpportx.
interface wbpportx_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/wbpportx_pp_fifo.sv
// First-word-fall-through FIFO with fill count and synchronous clear; used for both RX and TX.
module pp_fifo #(
    parameter int unsigned DW     = 8,
    parameter int unsigned LGFLEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            push,
    input  logic [DW-1:0]   push_data,
    input  logic            pop,
    output logic [DW-1:0]   head,
    output logic            empty,
    output logic            full,
    output logic [LGFLEN:0] fill
);
    localparam int unsigned   DEPTH     = 1 << LGFLEN;
    localparam logic [LGFLEN:0] DEPTH_CNT = (LGFLEN + 1)'(DEPTH);

    logic [DW-1:0]     mem [DEPTH];
    logic [LGFLEN-1:0] wr_ptr;
    logic [LGFLEN-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (fill == '0);
    assign full    = (fill == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wbpportx.sv
// Wishbone-slave parallel port with RX/TX FIFOs, sticky overflow flags and soft resets.
// Optional receive-idle timeout interrupt enabled by defining WBPPORTX_RXTIMEOUT_EN.
module wbpportx
    import wbpportx_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned LGFLEN   = 4,
    parameter logic [15:0] TOUT_DEF = 16'd1000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    wbpportx_if.slave     wb,
    input  logic          i_pp_stb,
    input  logic [DW-1:0] i_pp_data,
    output logic          o_pp_rxrdy,
    output logic          o_pp_stb,
    output logic [DW-1:0] o_pp_data,
    input  logic          i_pp_busy,
    output logic          o_rx_int,
    output logic          o_rxfifo_int,
    output logic          o_tx_int,
    output logic          o_txfifo_int,
    output logic          o_rxto_int
);
    localparam int unsigned LGF   = clamp_lgflen(LGFLEN);
    localparam int unsigned DEPTH = 1 << LGF;
    localparam logic [LGF:0] HALF = (LGF + 1)'(DEPTH / 2);

    logic          wb_req;
    logic          ctrl_wr;
    logic          tx_push;
    logic          rxreg_rd;
    logic          txreg_rd;
    logic          rx_clr;
    logic          tx_clr;
    logic          rx_accept;
    logic          rx_drop;
    logic          tx_pop;
    logic          tx_drop;
    logic          rx_ovfl;
    logic          tx_ovfl;
    logic [15:0]   tout_rd;
    logic [31:0]   rd_data;
    stat_word_t    rx_stat;
    stat_word_t    tx_stat;

    logic [DW-1:0] rx_head;
    logic          rx_empty;
    logic          rx_full;
    logic [LGF:0]  rx_fill;
    logic          tx_empty;
    logic          tx_full;
    logic [LGF:0]  tx_fill;

    logic          unused_wdata;

    // Bus decode
    assign wb_req    = wb.i_wb_cyc && wb.i_wb_stb;
    assign ctrl_wr   = wb_req &&  wb.i_wb_we && (wb.i_wb_addr == ADDR_CTRL);
    assign tx_push   = wb_req &&  wb.i_wb_we && (wb.i_wb_addr == ADDR_TXREG);
    assign rxreg_rd  = wb_req && !wb.i_wb_we && (wb.i_wb_addr == ADDR_RXREG);
    assign txreg_rd  = wb_req && !wb.i_wb_we && (wb.i_wb_addr == ADDR_TXREG);
    assign rx_clr    = ctrl_wr && wb.i_wb_data[CTRL_RXRST_BIT];
    assign tx_clr    = ctrl_wr && wb.i_wb_data[CTRL_TXRST_BIT];
    assign unused_wdata = ^wb.i_wb_data;

    // Link-side handshakes; rxrdy comes from registered fill so a same-cycle pop frees nothing
    assign rx_accept = i_pp_stb && !rx_full;
    assign rx_drop   = i_pp_stb &&  rx_full;
    assign tx_pop    = !tx_empty && !i_pp_busy;
    assign tx_drop   = tx_push && tx_full && !tx_pop;

    pp_fifo #(.DW(DW), .LGFLEN(LGF)) u_rx_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clr       (rx_clr),
        .push      (rx_accept),
        .push_data (i_pp_data),
        .pop       (rxreg_rd),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .fill      (rx_fill)
    );

    pp_fifo #(.DW(DW), .LGFLEN(LGF)) u_tx_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clr       (tx_clr),
        .push      (tx_push),
        .push_data (wb.i_wb_data[DW-1:0]),
        .pop       (tx_pop),
        .head      (o_pp_data),
        .empty     (tx_empty),
        .full      (tx_full),
        .fill      (tx_fill)
    );

    assign o_pp_rxrdy   = !rx_full;
    assign o_pp_stb     = !tx_empty;
    assign o_rx_int     = !rx_empty;
    assign o_rxfifo_int = (rx_fill >= HALF);
    assign o_tx_int     = !tx_full;
    assign o_txfifo_int = (tx_fill < HALF);

    // Sticky overflow flags: soft reset beats a new overflow, which beats the read-clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_ovfl <= 1'b0;
            tx_ovfl <= 1'b0;
        end else begin
            if (rx_clr)        rx_ovfl <= 1'b0;
            else if (rx_drop)  rx_ovfl <= 1'b1;
            else if (rxreg_rd) rx_ovfl <= 1'b0;

            if (tx_clr)        tx_ovfl <= 1'b0;
            else if (tx_drop)  tx_ovfl <= 1'b1;
            else if (txreg_rd) tx_ovfl <= 1'b0;
        end
    end

`ifdef WBPPORTX_RXTIMEOUT_EN
    logic [15:0] tout;
    logic [15:0] idle_cnt;

    // Idle counter restarts whenever RX sees activity or has nothing to report
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tout     <= TOUT_DEF;
            idle_cnt <= TOUT_DEF;
        end else begin
            if (ctrl_wr) tout <= wb.i_wb_data[15:0];
            if (rx_accept || rxreg_rd || rx_empty) idle_cnt <= tout;
            else if (idle_cnt != '0)               idle_cnt <= idle_cnt - 1'b1;
        end
    end

    assign o_rxto_int = (idle_cnt == '0) && !rx_empty && (tout != '0);
    assign tout_rd    = tout;
`else
    assign o_rxto_int = 1'b0;
    assign tout_rd    = '0;
`endif

    // Read-data mux, sampled at the strobe cycle
    always_comb begin
        rx_stat      = '0;
        tx_stat      = '0;
        rd_data      = '0;
        rx_stat.ovfl = rx_ovfl;
        rx_stat.flag = rx_empty;
        rx_stat.data = rx_empty ? 16'h0 : 16'(rx_head);
        tx_stat.ovfl = tx_ovfl;
        tx_stat.flag = tx_full;
        case (wb.i_wb_addr)
            ADDR_CTRL:  rd_data = {4'(LGF), 4'(DW - 1), 8'h00, tout_rd};
            ADDR_FIFO:  rd_data = {16'(tx_fill), 16'(rx_fill)};
            ADDR_RXREG: rd_data = rx_stat;
            default:    rd_data = tx_stat;
        endcase
    end

    assign wb.o_wb_stall = 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= '0;
        end else begin
            wb.o_wb_ack <= wb_req;
            if (wb_req) wb.o_wb_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_wbpportx.sv
// Self-checking bench for wbpportx: directed steps plus random traffic against a queue model.
module tb_wbpportx;
    import wbpportx_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
`ifdef WBPPORTX_RXTIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          pp_stb_in;
    logic [DW-1:0] pp_data_in;
    logic          pp_rxrdy;
    logic          pp_stb_out;
    logic [DW-1:0] pp_data_out;
    logic          pp_busy;
    logic          rx_int, rxfifo_int, tx_int, txfifo_int, rxto_int;

    wbpportx_if wbi();

    wbpportx #(.DW(DW), .LGFLEN(4), .TOUT_DEF(16'd1000)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .wb           (wbi),
        .i_pp_stb     (pp_stb_in),
        .i_pp_data    (pp_data_in),
        .o_pp_rxrdy   (pp_rxrdy),
        .o_pp_stb     (pp_stb_out),
        .o_pp_data    (pp_data_out),
        .i_pp_busy    (pp_busy),
        .o_rx_int     (rx_int),
        .o_rxfifo_int (rxfifo_int),
        .o_tx_int     (tx_int),
        .o_txfifo_int (txfifo_int),
        .o_rxto_int   (rxto_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    logic [DW-1:0] rxq[$];
    logic [DW-1:0] txq[$];
    bit            rx_ovfl_m;
    bit            tx_ovfl_m;
    logic [31:0]   rdat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        wbi.i_wb_cyc = 1'b1; wbi.i_wb_stb = 1'b1; wbi.i_wb_we = 1'b1;
        wbi.i_wb_addr = a;   wbi.i_wb_data = d;
        tick();
        wbi.i_wb_cyc = 1'b0; wbi.i_wb_stb = 1'b0; wbi.i_wb_we = 1'b0;
        check("wr_ack", 32'(wbi.o_wb_ack), 32'd1);
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        wbi.i_wb_cyc = 1'b1; wbi.i_wb_stb = 1'b1; wbi.i_wb_we = 1'b0;
        wbi.i_wb_addr = a;
        tick();
        wbi.i_wb_cyc = 1'b0; wbi.i_wb_stb = 1'b0;
        check("rd_ack", 32'(wbi.o_wb_ack), 32'd1);
        d = wbi.o_wb_data;
    endtask

    // One link-side receive strobe; the model decides acceptance from the pre-edge fill
    task automatic rx_strobe(input logic [DW-1:0] d);
        pp_stb_in = 1'b1; pp_data_in = d;
        tick();
        pp_stb_in = 1'b0;
        if (rxq.size() < DEPTH) rxq.push_back(d);
        else rx_ovfl_m = 1'b1;
    endtask

    task automatic rx_read(input string tag);
        logic [31:0] exp;
        logic [31:0] mask;
        exp  = {14'h0, rx_ovfl_m, rxq.size() == 0, 16'h0};
        mask = 32'hFFFF_FFFF;
        if (rxq.size() != 0) exp[DW-1:0] = rxq[0];
        else mask = 32'hFFFF_0000;
        wb_read(ADDR_RXREG, rdat);
        check(tag, rdat & mask, exp);
        if (rxq.size() != 0) void'(rxq.pop_front());
        rx_ovfl_m = 1'b0;
    endtask

    task automatic tx_write(input logic [DW-1:0] d);
        wb_write(ADDR_TXREG, 32'(d));
        if (txq.size() < DEPTH) txq.push_back(d);
        else tx_ovfl_m = 1'b1;
    endtask

    task automatic tx_status(input string tag);
        wb_read(ADDR_TXREG, rdat);
        check(tag, rdat, {14'h0, tx_ovfl_m, txq.size() == DEPTH, 16'h0});
        tx_ovfl_m = 1'b0;
    endtask

    task automatic tx_drain1();
        if (txq.size() != 0) check("drain_data", 32'(pp_data_out), 32'(txq[0]));
        pp_busy = 1'b0;
        tick();
        pp_busy = 1'b1;
        if (txq.size() != 0) void'(txq.pop_front());
    endtask

    task automatic fill_read(input string tag);
        wb_read(ADDR_FIFO, rdat);
        check(tag, rdat, {16'(txq.size()), 16'(rxq.size())});
    endtask

    // Level outputs follow directly from FIFO occupancy
    task automatic check_pins(input string tag, input bit chk_to);
        check({tag, "_rxrdy"},  32'(pp_rxrdy),   32'(rxq.size() < DEPTH));
        check({tag, "_ppstb"},  32'(pp_stb_out), 32'(txq.size() != 0));
        check({tag, "_rxint"},  32'(rx_int),     32'(rxq.size() != 0));
        check({tag, "_rxfint"}, 32'(rxfifo_int), 32'(rxq.size() >= DEPTH / 2));
        check({tag, "_txint"},  32'(tx_int),     32'(txq.size() < DEPTH));
        check({tag, "_txfint"}, 32'(txfifo_int), 32'(txq.size() < DEPTH / 2));
        if (txq.size() != 0) check({tag, "_ppdata"}, 32'(pp_data_out), 32'(txq[0]));
        if (chk_to) check({tag, "_rxto"}, 32'(rxto_int), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b0;
        wbi.i_wb_cyc = 1'b0; wbi.i_wb_stb = 1'b0; wbi.i_wb_we = 1'b0;
        wbi.i_wb_addr = '0;  wbi.i_wb_data = '0;
        pp_stb_in = 1'b0; pp_data_in = '0; pp_busy = 1'b1;
        rx_ovfl_m = 1'b0; tx_ovfl_m = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_ack",   32'(wbi.o_wb_ack),   32'd0);
        check("rst_data",  wbi.o_wb_data,       32'd0);
        check("rst_stall", 32'(wbi.o_wb_stall), 32'd0);
        check_pins("rst", 1'b1);

        wb_read(ADDR_CTRL, rdat);
        check("ctrl_rst", rdat, TO_EN ? 32'h4700_03E8 : 32'h4700_0000);
        tick();
        check("ack_drop", 32'(wbi.o_wb_ack), 32'd0);

        // Single TX word held by busy, then one transfer
        tx_write(8'hA5);
        check("tx_a5_stb",  32'(pp_stb_out),  32'd1);
        check("tx_a5_data", 32'(pp_data_out), 32'h0000_00A5);
        tick();
        check("tx_a5_hold", 32'(pp_stb_out),  32'd1);
        tx_drain1();
        check_pins("tx_a5_done", 1'b1);

        // 17 receive strobes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            rx_strobe(8'($urandom));
            check_pins("rxfill", 1'b1);
        end
        fill_read("fill_rx16");
        for (int i = 0; i < 17; i++) begin
            rx_read("rx_drain");
            check_pins("rxdrain", 1'b1);
        end
        rx_strobe(8'h3C);
        rx_read("rx_after_empty");

        // TX full, overflow, then push and pop in the same cycle
        for (int i = 0; i < 17; i++) tx_write(8'($urandom));
        check_pins("txfull", 1'b1);
        tx_status("tx_ovfl_set");
        tx_status("tx_ovfl_clr");
        d = 8'($urandom);
        check("simul_pre", 32'(pp_data_out), 32'(txq[0]));
        wbi.i_wb_cyc = 1'b1; wbi.i_wb_stb = 1'b1; wbi.i_wb_we = 1'b1;
        wbi.i_wb_addr = ADDR_TXREG; wbi.i_wb_data = 32'(d);
        pp_busy = 1'b0;
        tick();
        wbi.i_wb_cyc = 1'b0; wbi.i_wb_stb = 1'b0; wbi.i_wb_we = 1'b0;
        pp_busy = 1'b1;
        void'(txq.pop_front());
        txq.push_back(d);
        check("simul_ack", 32'(wbi.o_wb_ack), 32'd1);
        fill_read("fill_simul");
        tx_status("simul_status");
        for (int i = 0; i < 11; i++) tx_drain1();
        check_pins("tx5", 1'b1);

        // TX soft reset with 5 words queued, RX left alone
        for (int i = 0; i < 3; i++) rx_strobe(8'($urandom));
        wb_write(ADDR_CTRL, {14'h0, 2'b10, 16'd1000});
        txq.delete();
        tx_ovfl_m = 1'b0;
        check("txrst_stb", 32'(pp_stb_out), 32'd0);
        fill_read("fill_txrst");
        check_pins("txrst", 1'b1);
        for (int i = 0; i < 3; i++) rx_read("rx_after_txrst");

        // RX soft reset also clears a pending overflow
        for (int i = 0; i < 17; i++) rx_strobe(8'($urandom));
        wb_write(ADDR_CTRL, {14'h0, 2'b01, 16'd1000});
        rxq.delete();
        rx_ovfl_m = 1'b0;
        check_pins("rxrst", 1'b1);
        rx_read("rxrst_status");

        // Random mixed traffic
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: rx_strobe(8'($urandom));
                1: rx_read("rnd_rx");
                2: tx_write(8'($urandom));
                3: tx_drain1();
                default: tx_status("rnd_txstat");
            endcase
            check_pins("rnd", 1'b1);
        end
        fill_read("fill_rnd");
        while (rxq.size() != 0) rx_read("rnd_flush");
        wb_write(ADDR_CTRL, {14'h0, 2'b10, 16'd10});
        txq.delete();
        tx_ovfl_m = 1'b0;

        // Receive-idle timeout with tout=10
        wb_read(ADDR_CTRL, rdat);
        check("ctrl_tout10", rdat, TO_EN ? 32'h4700_000A : 32'h4700_0000);
        rx_strobe(8'h11);
        rx_strobe(8'h22);
        for (int k = 0; k <= 10; k++) begin
            check($sformatf("rxto_k%0d", k), 32'(rxto_int), 32'(TO_EN && k >= 10));
            if (k < 10) tick();
        end
        rx_read("rxto_read1");
        check("rxto_cleared", 32'(rxto_int), 32'd0);
        rx_read("rxto_read2");
        repeat (12) tick();
        check("rxto_empty", 32'(rxto_int), 32'd0);

        // tout=0 disables the interrupt
        wb_write(ADDR_CTRL, 32'd0);
        rx_strobe(8'h33);
        repeat (5) tick();
        check("rxto_disabled", 32'(rxto_int), 32'd0);
        rx_read("rxto_read3");
        check_pins("end", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wbpportx.md
# wbpportx

Wishbone-slave parallel-port controller, DW-bit wide, with separate receive and transmit FIFOs of depth 2^LGFLEN. It carries sticky overflow flags, receive back-pressure, per-FIFO soft reset and an optional receive-idle timeout interrupt. It sits on the peripheral Wishbone bus between the CPU and an external byte/word-parallel link. It is the parametrised successor of the fixed 7-bit parallel port.

## Interface
- DW, 8: parallel data width, 1..16.
- LGFLEN, 4: log2 FIFO depth, clamped to 2..10.
- TOUT_DEF, 16'd1000: reset value of the RX timeout, in clocks.
- i_clk  in  1  sole clock.
- i_rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone classic-pipelined controls.
- i_wb_addr  in  2  register select.
- i_wb_data  in  32  write data.
- o_wb_ack  out  1  acknowledge.
- o_wb_stall  out  1  tied 0.
- o_wb_data  out  32  read data.
- i_pp_stb  in  1  receive strobe.
- i_pp_data  in  DW  receive data.
- o_pp_rxrdy  out  1  receive ready; deasserted when the RX FIFO is full.
- o_pp_stb  out  1  transmit data valid.
- o_pp_data  out  DW  transmit data.
- i_pp_busy  in  1  transmit sink busy.
- o_rx_int, o_rxfifo_int, o_tx_int, o_txfifo_int, o_rxto_int  out  1  interrupts.

## Operation
- Address 0, CTRL.
  - Read: {LGFLEN[3:0], DW-1 [3:0], 8'h0, tout[15:0]}.
  - Write: tout <= data[15:0].
  - data[16]=1 resets RX; data[17]=1 resets TX.
- Address 1, FIFO: read {tx_fill[15:0], rx_fill[15:0]}, zero-extended. Writes are ignored.
- Address 2, RXREG.
  - Read: {14'h0, rx_ovfl, empty, (16-DW)'0, head}.
  - A read with RX non-empty pops the FIFO. Every read clears rx_ovfl. Writes are ignored.
- Address 3, TXREG.
  - Write pushes data[DW-1:0]. A write while full is dropped and sets tx_ovfl.
  - Read: {14'h0, tx_ovfl, full, (16-DW)'0, 16'h0 upper-aligned status only}. A read clears tx_ovfl.
- RX path:
  - A word is accepted when i_pp_stb && o_pp_rxrdy.
  - i_pp_stb with o_pp_rxrdy low drops the word and sets rx_ovfl.
  - o_pp_rxrdy = !rx_full from registered state. A pop in the same cycle does not make room for that cycle's strobe.
- TX path:
  - o_pp_stb = !tx_empty; o_pp_data = FIFO head (first-word-fall-through).
  - A transfer, and a pop, occur when o_pp_stb && !i_pp_busy.
  - A push to a full TX FIFO in the same cycle as a pp pop is accepted; fill is unchanged.
- Interrupts, all level:
  - o_rx_int = !rx_empty.
  - o_rxfifo_int = rx_fill >= depth/2.
  - o_tx_int = !tx_full.
  - o_txfifo_int = tx_fill < depth/2.
- Soft reset: a FIFO reset empties that FIFO and clears its ovfl flag on the next edge. A TX reset drops o_pp_stb mid-transfer.

## Timing
- Reset: o_wb_ack=0, o_wb_data=0, FIFOs empty, o_pp_stb=0, o_pp_rxrdy=1, ovfl flags=0, tout=TOUT_DEF, o_rxto_int=0. Consequently o_tx_int=1 and o_txfifo_int=1.
- Every i_wb_stb is acked exactly one clock later; o_wb_data is valid with o_wb_ack. No stalls.
- Data movement:
  - An RX pop, and the data it returns, are taken at the stb cycle.
  - A TX push is visible on o_pp_stb one clock after the stb.
  - RX data becomes readable one clock after acceptance.
- Fill counters are LGFLEN+1 bits, and read/write pointers wrap modulo depth.

## Configuration
- WBPPORTX_RXTIMEOUT_EN defined:
  - A 16-bit idle counter reloads to tout on any RX acceptance, any RXREG read, or when RX is empty.
  - Otherwise it decrements to 0.
  - o_rxto_int = (counter==0) && !rx_empty.
  - tout=0 disables the interrupt.
- Not defined: o_rxto_int is tied 0. The counter is absent, and CTRL[15:0] reads 0 with writes ignored.

## Structure
- Package wbpportx_pkg:
  - Register address constants.
  - Status bit positions: OVFL=17, EMPTY/FULL=16.
  - CTRL reset bit positions: 16 and 17.
  - The LGFLEN clamp function.
- Sub-module pp_fifo #(DW, LGFLEN), instantiated twice.
  - Ports: clk, rst_n, sync clear, push, push data, pop, head, empty, full, fill.
  - A push when full, without a pop, is ignored.
  - A pop when empty is ignored.

## Test plan
- Reset, then read CTRL with DW=8 and LGFLEN=4 -> 32'h4700_03E8, with o_tx_int=1, o_pp_rxrdy=1 and o_pp_stb=0.
- Write TXREG 8'hA5 with i_pp_busy=1 -> o_pp_stb=1 and o_pp_data=A5 one clock later. Drop busy -> one transfer, then o_pp_stb=0.
- Pulse i_pp_stb 17 times at depth 16 -> o_pp_rxrdy=0 after 16, and rx_ovfl=1. A RXREG read returns word 0 with bit17=1; the next read returns bit17=0.
- Read RXREG when empty -> bit16=1 and no pointer change. A push and pp pop on a full TX FIFO in the same cycle -> tx_fill stays 16 and tx_ovfl=0.
- Write CTRL data[17]=1 while TX holds 5 words -> tx_fill=0 and o_pp_stb=0 the next cycle. RX contents are unaffected.
- With WBPPORTX_RXTIMEOUT_EN and tout=10: one RX word, idle -> o_rxto_int=1 at 11 clocks. A RXREG read clears it.
